// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared types and constants for the instruction fetch stage
package instr_fetch_pkg;

  localparam logic [31:0] NOP_INST    = 32'h0000_0013;
  localparam int          FETCH_DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - two-entry synchronous FIFO with flush
module fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem [FETCH_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  // A pop frees the head slot, so a push is still accepted when full in the same cycle
  always_comb begin
    full    = (count == 2'(FETCH_DEPTH));
    empty   = (count == 2'd0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rdata   = mem[rd_ptr];
  end

  // Storage array; contents are only meaningful under count, so no reset needed
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; flush discards everything including a same-cycle push
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - program counter, imem request/response handling and decode buffer
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  logic [31:0]  pc_q;
  logic [1:0]   drop_cnt;
  logic [1:0]   out_cnt;
  logic [1:0]   fifo_count;
  logic         tag_full;
  logic         tag_empty;
  logic [31:0]  tag_head;
  logic         fifo_full;
  logic         fifo_empty;
  logic [63:0]  fifo_rdata;
  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic         rsp_fire;
  logic         pop_fire;
  logic         req_fire;
  logic         drop_now;
  logic         fifo_push;
  logic         fifo_pop;
  logic [2:0]   credit;

  // Handshake decode; the request is granted a slot when buffered plus live in-flight
  // words (after this cycle's pop) leave room, and the tag queue has space or frees one now
  always_comb begin
    rsp_fire       = imem_rsp_valid && !tag_empty;
    inst_valid     = !rst && !fifo_empty;
    pop_fire       = inst_valid && inst_ready;
    credit         = {1'b0, fifo_count} + {1'b0, out_cnt} - {1'b0, drop_cnt} - {2'b00, pop_fire};
    imem_req_valid = !rst && !redirect_valid && (credit < 3'(DEPTH)) && (!tag_full || rsp_fire);
    imem_req_addr  = pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    drop_now       = rsp_fire && (drop_cnt != 2'd0);
    fifo_pop       = pop_fire && !redirect_valid;
    fifo_push      = rsp_fire && !drop_now && !redirect_valid && (!fifo_full || fifo_pop);
    push_entry     = '{pc: tag_head, instr: imem_rsp_data};
    head           = fetch_entry_t'(fifo_rdata);
  end

  // Decode-facing outputs show a NOP at the reset PC whenever nothing valid is buffered
  always_comb begin
    if (rst || fifo_empty) begin
      instruction = NOP_INST;
      inst_pc     = RESET_PC;
    end else begin
      instruction = head.instr;
      inst_pc     = head.pc;
    end
  end

  // Program counter: reset, redirect target (word aligned), or advance on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= redirect_pc & ~32'h3;
    end else if (req_fire) begin
      pc_q <= pc_q + 32'd4;
    end
  end

  // Stale-response counter: a redirect marks every request still in flight as stale
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= 2'd0;
    end else if (redirect_valid) begin
      drop_cnt <= out_cnt - {1'b0, rsp_fire};
    end else if (drop_now) begin
      drop_cnt <= drop_cnt - 2'd1;
    end
  end

  // Address tags of issued requests; its occupancy is the outstanding-request count
  fetch_fifo #(.W(32)) u_tag_q (
    .clk   (clk),
    .rst   (rst),
    .push  (req_fire),
    .pop   (rsp_fire),
    .flush (1'b0),
    .wdata (pc_q),
    .rdata (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (out_cnt)
  );

  // Fetched {pc, instr} entries awaiting decode
  fetch_fifo #(.W($bits(fetch_entry_t))) u_out_q (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect_valid),
    .wdata (push_entry),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized self-checking bench with behavioural fetch model
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .instruction    (instruction),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {logic [31:0] addr; bit stale;} flight_t;
  typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
  typedef struct {logic [31:0] addr; int due;} mreq_t;

  flight_t     m_out[$];
  ent_t        m_fifo[$];
  mreq_t       mem_q[$];
  logic [31:0] m_pc = 32'h0;
  bit          spur_en = 0;
  int          lat_max = 1;

  logic        s_req_v;
  logic [31:0] s_addr;
  logic        s_inst_v;
  logic [31:0] s_pc;
  logic [31:0] s_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // One clock: drive inputs, predict, compare at negedge, then advance the model
  task automatic step(input bit r, input bit rdy, input bit ir, input bit rd, input logic [31:0] rp);
    bit          e_req_v, e_inst_v, rspf, pop;
    int          live;
    logic [31:0] e_addr, e_pc, e_instr;
    flight_t     f;
    rst            = r;
    imem_req_ready = rdy;
    inst_ready     = ir;
    redirect_valid = rd;
    redirect_pc    = rp;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (mem_q.size() > 0 && cyc >= mem_q[0].due) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else if (spur_en && mem_q.size() == 0 && m_out.size() == 0 && $urandom_range(0, 9) == 0) begin
      imem_rsp_valid = 1'b1;
    end
    live = 0;
    foreach (m_out[i]) if (!m_out[i].stale) live++;
    rspf     = imem_rsp_valid && (m_out.size() > 0);
    pop      = 0;
    e_addr   = m_pc;
    e_pc     = 32'h0;
    e_instr  = NOP_INST;
    if (r) begin
      e_req_v  = 0;
      e_inst_v = 0;
    end else begin
      e_inst_v = (m_fifo.size() > 0);
      pop      = e_inst_v && ir;
      e_req_v  = !rd && (m_fifo.size() - int'(pop) + live < 2) && (m_out.size() < 2 || rspf);
      if (e_inst_v) begin
        e_pc    = m_fifo[0].pc;
        e_instr = m_fifo[0].instr;
      end
    end
    @(negedge clk);
    s_req_v  = imem_req_valid;
    s_addr   = imem_req_addr;
    s_inst_v = inst_valid;
    s_pc     = inst_pc;
    s_instr  = instruction;
    chk("req_valid", 32'(s_req_v), 32'(e_req_v));
    if (e_req_v) chk("req_addr", s_addr, e_addr);
    chk("inst_valid", 32'(s_inst_v), 32'(e_inst_v));
    if (e_inst_v || r) begin
      chk("inst_pc", s_pc, e_pc);
      chk("instruction", s_instr, e_instr);
    end
    if (r) begin
      m_pc = 32'h0;
      m_out.delete();
      m_fifo.delete();
      mem_q.delete();
    end else begin
      if (pop && !rd) void'(m_fifo.pop_front());
      if (rspf) begin
        f = m_out.pop_front();
        if (!f.stale && !rd) m_fifo.push_back('{f.addr, imem_rsp_data});
      end
      if (rd) begin
        m_fifo.delete();
        foreach (m_out[i]) m_out[i].stale = 1;
        m_pc = rp & ~32'h3;
      end else if (e_req_v && rdy) begin
        m_out.push_back('{m_pc, 1'b0});
        mem_q.push_back('{m_pc, cyc + $urandom_range(1, lat_max)});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int  accepts;
    bit  seen;
    logic [31:0] rp;
    rst = 1'b1; imem_req_ready = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    @(posedge clk);
    #1;

    step(1, 1, 1, 0, 0);
    chk("rst_req_valid", 32'(s_req_v), 32'h0);
    chk("rst_inst_valid", 32'(s_inst_v), 32'h0);
    chk("rst_instruction", s_instr, 32'h0000_0013);
    chk("rst_inst_pc", s_pc, 32'h0);
    step(1, 1, 1, 0, 0);

    lat_max = 1;
    step(0, 1, 1, 0, 0);
    chk("first_req", {s_req_v, s_addr[30:0]}, 32'h8000_0000);
    step(0, 1, 1, 0, 0);
    chk("second_req_addr", s_addr, 32'h4);
    step(0, 1, 1, 0, 0);
    chk("third_req_addr", s_addr, 32'h8);
    chk("first_inst_pc", s_pc, 32'h0);
    chk("first_inst_data", s_instr, 32'h5A5A_0F0F);
    step(0, 1, 1, 0, 0);
    chk("second_inst_valid", 32'(s_inst_v), 32'h1);
    chk("second_inst_pc", s_pc, 32'h4);

    accepts = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 0, 0);
      if (s_req_v) accepts++;
    end
    chk("bp_accepts_le2", 32'(accepts <= 2), 32'h1);
    chk("bp_req_blocked", 32'(s_req_v), 32'h0);
    chk("bp_fifo_full_valid", 32'(s_inst_v), 32'h1);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0);

    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0);

    step(0, 1, 0, 1, 32'h0000_0103);
    step(0, 1, 1, 0, 0);
    chk("redir_inst_flushed", 32'(s_inst_v), 32'h0);
    chk("redir_req_valid", 32'(s_req_v), 32'h1);
    chk("redir_req_addr", s_addr, 32'h100);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(0, 1, 1, 0, 0);
      if (s_inst_v) begin
        seen = 1;
        chk("redir_first_pc", s_pc, 32'h100);
      end
    end
    chk("redir_delivery_seen", 32'(seen), 32'h1);

    lat_max = 3;
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 32'h0000_0200);
    step(0, 1, 1, 1, 32'h0000_0304);
    for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 0);

    for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    chk("midrst_inst_valid", 32'(s_inst_v), 32'h0);
    chk("midrst_instruction", s_instr, 32'h0000_0013);
    spur_en = 1;
    step(0, 1, 1, 0, 0);
    chk("midrst_restart_addr", s_addr, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      rp = $urandom;
      if ($urandom_range(0, 7) == 0) rp = 32'hFFFF_FFF0 | (rp & 32'hF);
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0, rp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
